// File: rtl/par_to_ser_shifter.sv
// par_to_ser_shifter: takes one DATA_W-bit word over a valid/ready handshake
// and emits it one bit per qualified cycle on ser_data/ser_valid. The outputs
// feed a serial odd-parity generator. GAP_CYCLES idle cycles separate
// consecutive bits of one word. ser_last marks the final bit of a word.
// Optional build macro SER_FRAME_CNT_EN adds a 16-bit frame_cnt output that
// counts completed words.

module par_to_ser_shifter #(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_last,
`ifdef SER_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = 4;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO   = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : GAP_ZERO;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    // Bit presented next from a word, honouring the configured bit order.
    function automatic logic head_bit(input logic [DATA_W-1:0] word);
        if (MSB_FIRST != 0) begin
            return word[DATA_W-1];
        end else begin
            return word[0];
        end
    endfunction

    // Word with its head bit removed, so the next head bit comes into place.
    function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] word);
        if (MSB_FIRST != 0) begin
            return {word[DATA_W-2:0], 1'b0};
        end else begin
            return {1'b0, word[DATA_W-1:1]};
        end
    endfunction

    // Next-state and next-output computation; abort overrides every state.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            sr_d    = {DATA_W{1'b0}};
            cnt_d   = CNT_ZERO;
            gap_d   = GAP_ZERO;
            data_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        // First bit goes out directly on the accept edge.
                        state_d = ST_SHIFT;
                        data_d  = head_bit(in_data);
                        sr_d    = drop_head(in_data);
                        cnt_d   = CNT_LOAD;
                        gap_d   = GAP_ZERO;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_ZERO) begin
                        // The bit on the wire was the final one; no trailing gap.
                        state_d = ST_IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_RELOAD;
                    end else begin
                        state_d = ST_SHIFT;
                        data_d  = head_bit(sr_q);
                        sr_d    = drop_head(sr_q);
                        cnt_d   = cnt_q - CNT_ONE;
                        valid_d = 1'b1;
                        last_d  = (cnt_q == CNT_ONE);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_ZERO) begin
                        state_d = ST_SHIFT;
                        data_d  = head_bit(sr_q);
                        sr_d    = drop_head(sr_q);
                        cnt_d   = cnt_q - CNT_ONE;
                        valid_d = 1'b1;
                        last_d  = (cnt_q == CNT_ONE);
                    end else begin
                        gap_d   = gap_q - GAP_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sr_d    = {DATA_W{1'b0}};
                    cnt_d   = CNT_ZERO;
                    gap_d   = GAP_ZERO;
                    data_d  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= {DATA_W{1'b0}};
            cnt_q   <= CNT_ZERO;
            gap_q   <= GAP_ZERO;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign ser_data  = data_q;
    assign ser_valid = valid_q;
    assign ser_last  = last_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

`ifdef SER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count every word whose last bit was emitted; abort does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
